// File: rtl/linear_pwm_pkg.sv
// Shared defaults and types for the linear_pwm fade generator.
package linear_pwm_pkg;
  localparam int          RES_DEF  = 8;
  localparam int          GRAD_DEF = 600;
  localparam logic [31:0] DVSR_DEF = 32'd48;

  typedef enum logic {RAMP_DOWN, RAMP_UP} ramp_dir_t;
endpackage

// File: rtl/linear_pwm_pwm_gen.sv
// Prescaled PWM counter with period-aligned duty shadow and registered compare output.
module pwm_gen
  import linear_pwm_pkg::*;
#(
  parameter int resolution = RES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           dvsr,
  input  logic [resolution-1:0] duty_in,
  output logic                  pwm_out
);
  localparam logic [resolution-1:0] D_ONE = resolution'(1);
  localparam logic [resolution-1:0] D_MAX = '1;

  logic [31:0]           q_q, q_d;
  logic [resolution-1:0] d_q, d_d;
  logic [resolution-1:0] shadow_q, shadow_d;
  logic                  pwm_q, pwm_d;
  logic                  tick;

  always_comb begin
    tick     = (q_q == dvsr);
    q_d      = tick ? 32'd0 : q_q + 32'd1;
    d_d      = tick ? d_q + D_ONE : d_q;
    // Shadow follows duty only at the last tick of a period so a period never glitches.
    shadow_d = (tick && d_q == D_MAX) ? duty_in : shadow_q;
    pwm_d    = (d_q < shadow_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q      <= '0;
      d_q      <= '0;
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      q_q      <= q_d;
      d_q      <= d_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
endmodule

// File: rtl/linear_pwm.sv
// LED fade PWM: gradient timer steps an internal duty ramp feeding pwm_gen.
// Define LINEAR_PWM_TRIANGLE_EN for a triangle ramp; default is a sawtooth.
module linear_pwm
  import linear_pwm_pkg::*;
#(
  parameter int          resolution  = RES_DEF,
  parameter int          grad_thresh = GRAD_DEF,
  parameter logic [31:0] dvsr        = DVSR_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic pwm_linear_out
);
  localparam int                    GW     = (grad_thresh > 1) ? $clog2(grad_thresh) : 1;
  localparam logic [GW-1:0]         G_LAST = GW'(grad_thresh - 1);
  localparam logic [GW-1:0]         G_ONE  = GW'(1);
  localparam logic [resolution-1:0] D_ONE  = resolution'(1);

  logic [GW-1:0]         g_q, g_d;
  logic                  step;
  logic [resolution-1:0] duty_q, duty_d;

  always_comb begin
    step = (g_q == G_LAST);
    g_d  = step ? '0 : g_q + G_ONE;
  end

`ifdef LINEAR_PWM_TRIANGLE_EN
  localparam logic [resolution-1:0] D_MAX = '1;
  ramp_dir_t dir_q, dir_d;

  // Turn around at the endpoints without repeating them.
  always_comb begin
    dir_d  = dir_q;
    duty_d = duty_q;
    if (step) begin
      if (dir_q == RAMP_UP) begin
        if (duty_q == D_MAX) begin
          duty_d = duty_q - D_ONE;
          dir_d  = RAMP_DOWN;
        end else begin
          duty_d = duty_q + D_ONE;
        end
      end else begin
        if (duty_q == '0) begin
          duty_d = D_ONE;
          dir_d  = RAMP_UP;
        end else begin
          duty_d = duty_q - D_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir_q <= RAMP_UP;
    else     dir_q <= dir_d;
  end
`else
  always_comb begin
    duty_d = step ? duty_q + D_ONE : duty_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q    <= '0;
      duty_q <= '0;
    end else begin
      g_q    <= g_d;
      duty_q <= duty_d;
    end
  end

  pwm_gen #(.resolution(resolution)) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .dvsr    (dvsr),
    .duty_in (duty_q),
    .pwm_out (pwm_linear_out)
  );
endmodule

// File: tb/tb_linear_pwm.sv
// Directed checks of linear_pwm across several parameter sets, 8 ns clock.
module tb_linear_pwm;
  logic clk = 1'b0;
  logic rst;
  logic o_def, o2, o3, o4, o5;

  always #4 clk = ~clk;

  linear_pwm u_def (.clk(clk), .rst(rst), .pwm_linear_out(o_def));
  linear_pwm #(.resolution(4), .grad_thresh(1000), .dvsr(32'd1)) u2 (.clk(clk), .rst(rst), .pwm_linear_out(o2));
  linear_pwm #(.resolution(4), .grad_thresh(16),   .dvsr(32'd0)) u3 (.clk(clk), .rst(rst), .pwm_linear_out(o3));
  linear_pwm #(.resolution(4), .grad_thresh(2),    .dvsr(32'd0)) u4 (.clk(clk), .rst(rst), .pwm_linear_out(o4));
  linear_pwm #(.resolution(4), .grad_thresh(1),    .dvsr(32'd0)) u5 (.clk(clk), .rst(rst), .pwm_linear_out(o5));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    int   hi2 = 0, hi3a = 0, hi3b = 0, rise3 = 0, hidef = 0;
    int   r1 = 0, r2 = 0, nrise = 0;
    logic p3 = 1'b0, pdef = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out",    int'(o_def), 0);
    chk("rst_presc",  int'(u_def.u_pwm.q_q), 0);
    chk("rst_cnt",    int'(u_def.u_pwm.d_q), 0);
    chk("rst_grad",   int'(u_def.g_q), 0);
    chk("rst_duty",   int'(u_def.duty_q), 0);
    chk("rst_shadow", int'(u_def.u_pwm.shadow_q), 0);
    rst = 1'b0;

    for (int n = 1; n <= 50180; n++) begin
      @(negedge clk);

      // res=4, dvsr=1: tick every 2 clocks, 32-clock period, duty stays 0
      if (o2) hi2++;
      case (n)
        2:    chk("t2_d_n2", int'(u2.u_pwm.d_q), 1);
        3:    chk("t2_d_n3", int'(u2.u_pwm.d_q), 1);
        31:   chk("t2_d_n31", int'(u2.u_pwm.d_q), 15);
        32:   chk("t2_d_wrap", int'(u2.u_pwm.d_q), 0);
        1000: chk("t2_out_low", hi2, 0);
        default: ;
      endcase

      // res=4, dvsr=0, grad=16: shadow=5 loaded at edge 96, 6 at edge 112
      if (n >= 97 && n <= 112 && o3) hi3a++;
      if (n >= 113 && n <= 128 && o3) hi3b++;
      if (n >= 90 && o3 && !p3 && rise3 == 0) rise3 = n;
      p3 = o3;
      if (n == 96) chk("t3_d_zero", int'(u3.u_pwm.d_q), 0);
      if (n == 128) begin
        chk("t3_high5", hi3a, 5);
        chk("t3_high6", hi3b, 6);
        chk("t3_rise",  rise3, 97);
      end

      // sawtooth grad=2: shadow only moves when d wraps; pre-step duty on coincident step
      case (n)
        15: chk("t4_sh15", int'(u4.u_pwm.shadow_q), 0);
        16: chk("t4_sh16", int'(u4.u_pwm.shadow_q), 7);
        31: begin
          chk("t4_sh31",   int'(u4.u_pwm.shadow_q), 7);
          chk("t4_duty31", int'(u4.duty_q), 15);
        end
        32: begin
          chk("t4_sh32",   int'(u4.u_pwm.shadow_q), 15);
          chk("t4_duty32", int'(u4.duty_q), 0);
        end
        48: chk("t4_sh48", int'(u4.u_pwm.shadow_q), 7);
        default: ;
      endcase

      // grad=1: one duty step per clock
      case (n)
        15: chk("t5_duty15", int'(u5.duty_q), 15);
`ifdef LINEAR_PWM_TRIANGLE_EN
        16: chk("t5_duty16", int'(u5.duty_q), 14);
        30: chk("t5_duty30", int'(u5.duty_q), 0);
        31: chk("t5_duty31", int'(u5.duty_q), 1);
        45: chk("t5_duty45", int'(u5.duty_q), 15);
        46: chk("t5_duty46", int'(u5.duty_q), 14);
`else
        16: chk("t5_duty16", int'(u5.duty_q), 0);
        30: chk("t5_duty30", int'(u5.duty_q), 14);
        31: chk("t5_duty31", int'(u5.duty_q), 15);
`endif
        default: ;
      endcase

      // defaults: 12544-clock period, shadows 20/41/62 -> 49 clocks high per duty unit
      if (o_def) hidef++;
      if (o_def && !pdef) begin
        nrise++;
        if (nrise == 1) r1 = n;
        if (nrise == 2) r2 = n;
      end
      pdef = o_def;
      case (n)
        12544: begin chk("t6_hi_p0", hidef, 0);    hidef = 0; end
        25088: begin chk("t6_hi_p1", hidef, 980);  hidef = 0; end
        37632: begin chk("t6_hi_p2", hidef, 2009); hidef = 0; end
        50176: begin chk("t6_hi_p3", hidef, 3038); hidef = 0; end
        default: ;
      endcase
      if (n == 25090) begin
        chk("t6_rise1",  r1, 12545);
        chk("t6_rise2",  r2, 25089);
        chk("t6_period", r2 - r1, 12544);
      end
    end

    // async reset mid-high-phase must clear the output with no clock edge
    chk("t6_high_pre_rst", int'(o_def), 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_out",   int'(o_def), 0);
    chk("t6_rst_presc", int'(u_def.u_pwm.q_q), 0);
    chk("t6_rst_duty",  int'(u_def.duty_q), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
